// File: rtl/ddr5_phy_pkg.sv
// Shared types and helpers for the DDR5 PHY phase serializer slice.
package ddr5_phy_pkg;

    localparam int DFI_ADDR_W = 14;

    typedef logic [2:0] phase_idx_t;

    typedef enum logic [1:0] {
        RATIO_1_1 = 2'b00,
        RATIO_1_2 = 2'b01,
        RATIO_1_4 = 2'b10,
        RATIO_1_8 = 2'b11
    } freq_ratio_e;

    // Number of DFI phases carried per frame for a given ratio code.
    function automatic logic [3:0] ratio_to_nph(input freq_ratio_e ratio);
        logic [3:0] nph;
        case (ratio)
            RATIO_1_1: nph = 4'd1;
            RATIO_1_2: nph = 4'd2;
            RATIO_1_4: nph = 4'd4;
            RATIO_1_8: nph = 4'd8;
            default:   nph = 4'd1;
        endcase
        return nph;
    endfunction

endpackage

// File: rtl/ddr5_phy_phase_serializer_if.sv
// DFI-side frame bus and serialized PHY-side outputs of the phase serializer.
interface ddr5_phy_phase_serializer_if #(
    parameter int pMAX_PHASES = 4,
    parameter int pNUM_RANK   = 2,
    parameter int pDRAM_SIZE  = 4
) ();

    // Frame inputs (phase p at [p*W +: W])
    logic                                          enable_i;
    logic [1:0]                                    dfi_freq_ratio_i;
    logic [pMAX_PHASES*pNUM_RANK-1:0]              dfi_cs_n_i;
    logic [pMAX_PHASES*pNUM_RANK-1:0]              dfi_reset_n_i;
    logic [pMAX_PHASES*ddr5_phy_pkg::DFI_ADDR_W-1:0] dfi_address_i;
    logic [pMAX_PHASES-1:0]                        dfi_wrdata_en_i;
    logic [pMAX_PHASES*2*pDRAM_SIZE-1:0]           dfi_wrdata_i;
    logic [pMAX_PHASES*(pDRAM_SIZE/4)-1:0]         dfi_wrdata_mask_i;

    // Serialized outputs and status
    logic                                          frame_ack_o;
    ddr5_phy_pkg::phase_idx_t                      phase_o;
    logic                                          ratio_err_o;
    logic [pNUM_RANK-1:0]                          dfi_cs_n_o;
    logic [pNUM_RANK-1:0]                          dfi_reset_n_o;
    logic [ddr5_phy_pkg::DFI_ADDR_W-1:0]           dfi_address_o;
    logic                                          dfi_wrdata_en_o;
    logic [2*pDRAM_SIZE-1:0]                       dfi_wrdata_o;
    logic [(pDRAM_SIZE/4)-1:0]                     dfi_wrdata_mask_o;

    modport master (
        output enable_i, dfi_freq_ratio_i, dfi_cs_n_i, dfi_reset_n_i,
               dfi_address_i, dfi_wrdata_en_i, dfi_wrdata_i, dfi_wrdata_mask_i,
        input  frame_ack_o, phase_o, ratio_err_o, dfi_cs_n_o, dfi_reset_n_o,
               dfi_address_o, dfi_wrdata_en_o, dfi_wrdata_o, dfi_wrdata_mask_o
    );

    modport slave (
        input  enable_i, dfi_freq_ratio_i, dfi_cs_n_i, dfi_reset_n_i,
               dfi_address_i, dfi_wrdata_en_i, dfi_wrdata_i, dfi_wrdata_mask_i,
        output frame_ack_o, phase_o, ratio_err_o, dfi_cs_n_o, dfi_reset_n_o,
               dfi_address_o, dfi_wrdata_en_o, dfi_wrdata_o, dfi_wrdata_mask_o
    );

endinterface

// File: rtl/ddr5_phy_phase_counter.sv
// Phase counter: frame sequencing, ratio latch, legality check and status flags.
module ddr5_phy_phase_counter
    import ddr5_phy_pkg::*;
#(
    parameter int pMAX_PHASES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic [1:0] ratio_i,
    output phase_idx_t cnt_o,
    output logic       frame_start_o,
    output logic       frame_ack_o,
    output logic       ratio_err_o
);

    localparam logic [3:0] MAX_NPH = 4'(pMAX_PHASES);

    phase_idx_t  cnt_q, cnt_d;
    freq_ratio_e ratio_q, ratio_d;
    logic        err_q, err_d;
    logic        ack_q, ack_d;

    freq_ratio_e req_s;
    logic        legal_s;
    logic        start_s;
    logic        last_s;
    logic [3:0]  nph_s;

    // Next-state: latch legal ratio at frame start, wrap counter at the frame's last phase.
    always_comb begin
        req_s   = freq_ratio_e'(ratio_i);
        legal_s = (ratio_to_nph(req_s) <= MAX_NPH);
        start_s = enable_i && (cnt_q == 3'd0);
        ratio_d = ratio_q;
        err_d   = err_q;
        if (start_s) begin
            if (legal_s) begin
                ratio_d = req_s;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            ratio_d = ratio_q;
        end
        // ratio_d is the ratio governing the frame in progress (mid-frame it equals ratio_q)
        nph_s  = ratio_to_nph(ratio_d);
        last_s = ({1'b0, cnt_q} == (nph_s - 4'd1));
        if (!enable_i) begin
            cnt_d = 3'd0;
        end else if (last_s) begin
            cnt_d = 3'd0;
        end else begin
            cnt_d = cnt_q + 3'd1;
        end
        ack_d = start_s;
    end

    // Sequencing state with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= 3'd0;
            ratio_q <= RATIO_1_1;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
        end
    end

    assign cnt_o         = cnt_q;
    assign frame_start_o = start_s;
    assign frame_ack_o   = ack_q;
    assign ratio_err_o   = err_q;

endmodule

// File: rtl/ddr5_phy_phase_serializer.sv
// DDR5 PHY write-path phase serializer: captures a DFI frame and replays one phase per clock.
module ddr5_phy_phase_serializer
    import ddr5_phy_pkg::*;
#(
    parameter int pMAX_PHASES = 4,
    parameter int pNUM_RANK   = 2,
    parameter int pDRAM_SIZE  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    ddr5_phy_phase_serializer_if.slave    dfi
);

    localparam int CS_W = pNUM_RANK;
    localparam int A_W  = DFI_ADDR_W;
    localparam int DQ_W = 2 * pDRAM_SIZE;
    localparam int DM_W = pDRAM_SIZE / 4;

    phase_idx_t cnt_s;
    logic       start_s;

    // Frame buffer, one packed slot per phase
    logic [pMAX_PHASES*CS_W-1:0] cs_buf_q, cs_buf_d;
    logic [pMAX_PHASES*CS_W-1:0] rn_buf_q, rn_buf_d;
    logic [pMAX_PHASES*A_W-1:0]  a_buf_q,  a_buf_d;
    logic [pMAX_PHASES-1:0]      en_buf_q, en_buf_d;
    logic [pMAX_PHASES*DQ_W-1:0] dq_buf_q, dq_buf_d;
    logic [pMAX_PHASES*DM_W-1:0] dm_buf_q, dm_buf_d;

    // Buffered phase selected by the counter
    logic [CS_W-1:0] cs_sel_s, rn_sel_s;
    logic [A_W-1:0]  a_sel_s;
    logic            en_sel_s;
    logic [DQ_W-1:0] dq_sel_s;
    logic [DM_W-1:0] dm_sel_s;

    // Output registers
    logic [CS_W-1:0] cs_q, cs_d, rn_q, rn_d;
    logic [A_W-1:0]  a_q, a_d;
    logic            en_q, en_d;
    logic [DQ_W-1:0] dq_q, dq_d;
    logic [DM_W-1:0] dm_q, dm_d;
    phase_idx_t      phase_q, phase_d;

    ddr5_phy_phase_counter #(
        .pMAX_PHASES(pMAX_PHASES)
    ) u_counter (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .enable_i      (dfi.enable_i),
        .ratio_i       (dfi.dfi_freq_ratio_i),
        .cnt_o         (cnt_s),
        .frame_start_o (start_s),
        .frame_ack_o   (dfi.frame_ack_o),
        .ratio_err_o   (dfi.ratio_err_o)
    );

    // Capture the whole frame at frame start, otherwise hold.
    always_comb begin
        if (start_s) begin
            cs_buf_d = dfi.dfi_cs_n_i;
            rn_buf_d = dfi.dfi_reset_n_i;
            a_buf_d  = dfi.dfi_address_i;
            en_buf_d = dfi.dfi_wrdata_en_i;
            dq_buf_d = dfi.dfi_wrdata_i;
            dm_buf_d = dfi.dfi_wrdata_mask_i;
        end else begin
            cs_buf_d = cs_buf_q;
            rn_buf_d = rn_buf_q;
            a_buf_d  = a_buf_q;
            en_buf_d = en_buf_q;
            dq_buf_d = dq_buf_q;
            dm_buf_d = dm_buf_q;
        end
    end

    // Select the buffered phase addressed by the counter.
    always_comb begin
        cs_sel_s = cs_buf_q[CS_W-1:0];
        rn_sel_s = rn_buf_q[CS_W-1:0];
        a_sel_s  = a_buf_q[A_W-1:0];
        en_sel_s = en_buf_q[0];
        dq_sel_s = dq_buf_q[DQ_W-1:0];
        dm_sel_s = dm_buf_q[DM_W-1:0];
        for (int p = 0; p < pMAX_PHASES; p++) begin
            if (cnt_s == phase_idx_t'(p)) begin
                cs_sel_s = cs_buf_q[p*CS_W +: CS_W];
                rn_sel_s = rn_buf_q[p*CS_W +: CS_W];
                a_sel_s  = a_buf_q[p*A_W +: A_W];
                en_sel_s = en_buf_q[p];
                dq_sel_s = dq_buf_q[p*DQ_W +: DQ_W];
                dm_sel_s = dm_buf_q[p*DM_W +: DM_W];
            end else begin
                cs_sel_s = cs_sel_s;
            end
        end
    end

    // Output next-state: phase 0 straight from the inputs, later phases from the buffer.
    always_comb begin
        if (start_s) begin
            cs_d    = dfi.dfi_cs_n_i[CS_W-1:0];
            rn_d    = dfi.dfi_reset_n_i[CS_W-1:0];
            a_d     = dfi.dfi_address_i[A_W-1:0];
            en_d    = dfi.dfi_wrdata_en_i[0];
            dq_d    = dfi.dfi_wrdata_i[DQ_W-1:0];
            dm_d    = dfi.dfi_wrdata_mask_i[DM_W-1:0];
            phase_d = 3'd0;
        end else if (dfi.enable_i) begin
            cs_d    = cs_sel_s;
            rn_d    = rn_sel_s;
            a_d     = a_sel_s;
            en_d    = en_sel_s;
            dq_d    = dq_sel_s;
            dm_d    = dm_sel_s;
            phase_d = cnt_s;
        end else begin
            cs_d    = cs_q;
            rn_d    = rn_q;
            a_d     = a_q;
            en_d    = en_q;
            dq_d    = dq_q;
            dm_d    = dm_q;
            phase_d = phase_q;
        end
    end

    // Frame buffer and output registers; cs_n resets to deselected.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cs_buf_q <= {(pMAX_PHASES*CS_W){1'b1}};
            rn_buf_q <= '0;
            a_buf_q  <= '0;
            en_buf_q <= '0;
            dq_buf_q <= '0;
            dm_buf_q <= '0;
            cs_q     <= {CS_W{1'b1}};
            rn_q     <= '0;
            a_q      <= '0;
            en_q     <= 1'b0;
            dq_q     <= '0;
            dm_q     <= '0;
            phase_q  <= 3'd0;
        end else begin
            cs_buf_q <= cs_buf_d;
            rn_buf_q <= rn_buf_d;
            a_buf_q  <= a_buf_d;
            en_buf_q <= en_buf_d;
            dq_buf_q <= dq_buf_d;
            dm_buf_q <= dm_buf_d;
            cs_q     <= cs_d;
            rn_q     <= rn_d;
            a_q      <= a_d;
            en_q     <= en_d;
            dq_q     <= dq_d;
            dm_q     <= dm_d;
            phase_q  <= phase_d;
        end
    end

    assign dfi.dfi_cs_n_o        = cs_q;
    assign dfi.dfi_reset_n_o     = rn_q;
    assign dfi.dfi_address_o     = a_q;
    assign dfi.dfi_wrdata_en_o   = en_q;
    assign dfi.dfi_wrdata_o      = dq_q;
    assign dfi.dfi_wrdata_mask_o = dm_q;
    assign dfi.phase_o           = phase_q;

endmodule

// File: tb/tb_ddr5_phy_phase_serializer.sv
// Directed self-checking bench for ddr5_phy_phase_serializer (4-phase and 8-phase builds).
module tb_ddr5_phy_phase_serializer;
    import ddr5_phy_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_i = ~clk_i;

    ddr5_phy_phase_serializer_if #(.pMAX_PHASES(4), .pNUM_RANK(2), .pDRAM_SIZE(4)) if4 ();
    ddr5_phy_phase_serializer_if #(.pMAX_PHASES(8), .pNUM_RANK(2), .pDRAM_SIZE(4)) if8 ();

    ddr5_phy_phase_serializer #(.pMAX_PHASES(4), .pNUM_RANK(2), .pDRAM_SIZE(4)) dut4 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .dfi   (if4.slave)
    );

    ddr5_phy_phase_serializer #(.pMAX_PHASES(8), .pNUM_RANK(2), .pDRAM_SIZE(4)) dut8 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .dfi   (if8.slave)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic step4(input string tag, input int ph, input logic [7:0] dq, input logic ack);
        tick();
        check({tag, ".phase"},  64'(if4.phase_o),      64'(ph));
        check({tag, ".wrdata"}, 64'(if4.dfi_wrdata_o), 64'(dq));
        check({tag, ".ack"},    64'(if4.frame_ack_o),  64'(ack));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_cs [4];
        exp_cs = '{2'b00, 2'b11, 2'b01, 2'b10};

        rst_i = 1'b0;
        if4.enable_i = 1'b0; if4.dfi_freq_ratio_i = 2'b00;
        if4.dfi_cs_n_i = '0; if4.dfi_reset_n_i = '0; if4.dfi_address_i = '0;
        if4.dfi_wrdata_en_i = '0; if4.dfi_wrdata_i = '0; if4.dfi_wrdata_mask_i = '0;
        if8.enable_i = 1'b0; if8.dfi_freq_ratio_i = 2'b00;
        if8.dfi_cs_n_i = '0; if8.dfi_reset_n_i = '0; if8.dfi_address_i = '0;
        if8.dfi_wrdata_en_i = '0; if8.dfi_wrdata_i = '0; if8.dfi_wrdata_mask_i = '0;
        repeat (2) @(posedge clk_i);
        #1;

        // Reset values
        check("rst.cs_n",    64'(if4.dfi_cs_n_o),      64'(2'b11));
        check("rst.reset_n", 64'(if4.dfi_reset_n_o),   64'(0));
        check("rst.addr",    64'(if4.dfi_address_o),   64'(0));
        check("rst.wren",    64'(if4.dfi_wrdata_en_o), 64'(0));
        check("rst.wrdata",  64'(if4.dfi_wrdata_o),    64'(0));
        check("rst.mask",    64'(if4.dfi_wrdata_mask_o), 64'(0));
        check("rst.phase",   64'(if4.phase_o),         64'(0));
        check("rst.ack",     64'(if4.frame_ack_o),     64'(0));
        check("rst.err",     64'(if4.ratio_err_o),     64'(0));
        check("rst8.cs_n",   64'(if8.dfi_cs_n_o),      64'(2'b11));

        rst_i = 1'b1;
        tick();

        // 1:4 replay of address/cs_n/wrdata_en/mask
        if4.dfi_freq_ratio_i = 2'b10;
        if4.dfi_address_i    = {14'h0044, 14'h0033, 14'h0022, 14'h0011};
        if4.dfi_cs_n_i       = 8'b10_01_11_00;
        if4.dfi_reset_n_i    = 8'hFF;
        if4.dfi_wrdata_en_i  = 4'b1010;
        if4.dfi_wrdata_mask_i = 4'b0110;
        if4.enable_i         = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int k;
            k = i % 4;
            tick();
            check("r14.addr",    64'(if4.dfi_address_o),     64'((k + 1) * 17));
            check("r14.cs_n",    64'(if4.dfi_cs_n_o),        64'(exp_cs[k]));
            check("r14.phase",   64'(if4.phase_o),           64'(k));
            check("r14.ack",     64'(if4.frame_ack_o),       64'(k == 0));
            check("r14.wren",    64'(if4.dfi_wrdata_en_o),   64'(k % 2));
            check("r14.mask",    64'(if4.dfi_wrdata_mask_o), 64'((k == 1) || (k == 2)));
            check("r14.reset_n", 64'(if4.dfi_reset_n_o),     64'(2'b11));
        end

        // 1:2, inputs changed after capture do not disturb the frame
        if4.dfi_freq_ratio_i = 2'b01;
        if4.dfi_wrdata_i     = 32'h0000_5AA5;
        step4("t2a", 0, 8'hA5, 1'b1);
        if4.dfi_wrdata_i     = 32'h0000_3CC3;
        step4("t2b", 1, 8'h5A, 1'b0);
        step4("t2c", 0, 8'hC3, 1'b1);
        step4("t2d", 1, 8'h3C, 1'b0);

        // Ratio 10 -> 01 at counter==1: frame finishes all 4 phases
        if4.dfi_freq_ratio_i = 2'b10;
        if4.dfi_wrdata_i     = 32'h4433_2211;
        step4("t3a", 0, 8'h11, 1'b1);
        if4.dfi_freq_ratio_i = 2'b01;
        step4("t3b", 1, 8'h22, 1'b0);
        step4("t3c", 2, 8'h33, 1'b0);
        step4("t3d", 3, 8'h44, 1'b0);
        step4("t3e", 0, 8'h11, 1'b1);
        step4("t3f", 1, 8'h22, 1'b0);
        step4("t3g", 0, 8'h11, 1'b1);

        // Back to 1:4, then illegal 1:8 on a 4-phase build
        if4.dfi_freq_ratio_i = 2'b10;
        step4("t4a", 1, 8'h22, 1'b0);
        step4("t4b", 0, 8'h11, 1'b1);
        if4.dfi_freq_ratio_i = 2'b11;
        step4("t4c", 1, 8'h22, 1'b0);
        step4("t4d", 2, 8'h33, 1'b0);
        step4("t4e", 3, 8'h44, 1'b0);
        check("t4.err_before", 64'(if4.ratio_err_o), 64'(0));
        step4("t4f", 0, 8'h11, 1'b1);
        check("t4.err_set", 64'(if4.ratio_err_o), 64'(1));
        step4("t4g", 1, 8'h22, 1'b0);
        step4("t4h", 2, 8'h33, 1'b0);
        step4("t4i", 3, 8'h44, 1'b0);
        step4("t4j", 0, 8'h11, 1'b1);
        check("t4.err_sticky", 64'(if4.ratio_err_o), 64'(1));

        // Disable at counter==2: outputs hold, re-enable starts a fresh frame
        if4.dfi_freq_ratio_i = 2'b10;
        step4("t5a", 1, 8'h22, 1'b0);
        if4.enable_i = 1'b0;
        step4("t5b", 1, 8'h22, 1'b0);
        if4.dfi_wrdata_i = 32'h4847_4645;
        step4("t5c", 1, 8'h22, 1'b0);
        if4.enable_i = 1'b1;
        step4("t5d", 0, 8'h45, 1'b1);
        step4("t5e", 1, 8'h46, 1'b0);
        step4("t5f", 2, 8'h47, 1'b0);
        check("t5.cs_n_pre",  64'(if4.dfi_cs_n_o), 64'(2'b01));
        check("t5.err_pre",   64'(if4.ratio_err_o), 64'(1));

        // Asynchronous reset mid-frame
        rst_i = 1'b0;
        #1;
        check("t6.cs_n",    64'(if4.dfi_cs_n_o),      64'(2'b11));
        check("t6.reset_n", 64'(if4.dfi_reset_n_o),   64'(0));
        check("t6.addr",    64'(if4.dfi_address_o),   64'(0));
        check("t6.wrdata",  64'(if4.dfi_wrdata_o),    64'(0));
        check("t6.phase",   64'(if4.phase_o),         64'(0));
        check("t6.ack",     64'(if4.frame_ack_o),     64'(0));
        check("t6.err",     64'(if4.ratio_err_o),     64'(0));
        tick();
        rst_i = 1'b1;
        tick();

        // 8-phase build: 1:8 is legal
        if8.dfi_freq_ratio_i = 2'b11;
        if8.dfi_wrdata_i     = 64'h0807_0605_0403_0201;
        if8.enable_i         = 1'b1;
        for (int i = 0; i < 10; i++) begin
            int k;
            k = i % 8;
            tick();
            check("r18.phase",  64'(if8.phase_o),      64'(k));
            check("r18.wrdata", 64'(if8.dfi_wrdata_o), 64'(k + 1));
            check("r18.ack",    64'(if8.frame_ack_o),  64'(k == 0));
            check("r18.err",    64'(if8.ratio_err_o),  64'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
